mra_resp_unit: RTL and testbench

Memory-side responder for the tensor-core MRA read-request interface. It accepts line read requests from the dispatch-side MRA controller, forwards them in order to the memory port, buffers the returned 64-byte lines, and writes each line as one entry into the work-item queue FIFO. It is credit-limited, so memory responses never need backpressure and the FIFO is never overrun.

---
 rtl/tc_mra_pkg.sv | 12 +
 rtl/mra_resp_unit_if.sv | 52 +++++
 rtl/tc_sync_fifo.sv | 69 ++++++
 rtl/mra_resp_unit.sv | 101 ++++++++++
 tb/tb_mra_resp_unit.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tc_mra_pkg.sv
// rtl/tc_mra_pkg.sv - shared constants for the tensor-core MRA request path
// Line geometry and read/write encoding of MRA_rw, used by both the
// dispatch-side controller and the memory-side responder.
package tc_mra_pkg;

   localparam int LINE_BYTES    = 64;
   localparam int LINE_OFS_BITS = 6;

   localparam logic MRA_RW_READ  = 1'b0;
   localparam logic MRA_RW_WRITE = 1'b1;

endpackage

// File: rtl/mra_resp_unit_if.sv
// rtl/mra_resp_unit_if.sv - MRA request, memory port and WI-queue bundle
// Signals:
//   MRA_req_addr/MRA_rw/MRA_req_valid/MRA_ready : controller request channel
//   mem_req_valid/mem_req_addr/mem_req_ready    : memory read request channel
//   mem_rsp_valid/mem_rsp_data                  : memory read data, no backpressure
//   FIFO_wr_en/FIFO_wr_data/FIFO_full           : work-item queue write port
//   busy/err                                    : responder status
// Modports: slave = responder, master = surrounding environment.
interface mra_resp_unit_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 512
) ();

   logic [ADDR_WIDTH-1:0] MRA_req_addr;
   logic                  MRA_rw;
   logic                  MRA_req_valid;
   logic                  MRA_ready;

   logic                  mem_req_valid;
   logic [ADDR_WIDTH-1:0] mem_req_addr;
   logic                  mem_req_ready;
   logic                  mem_rsp_valid;
   logic [DATA_WIDTH-1:0] mem_rsp_data;

   logic                  FIFO_wr_en;
   logic [DATA_WIDTH-1:0] FIFO_wr_data;
   logic                  FIFO_full;

   logic                  busy;
   logic                  err;

   modport slave (
      input  MRA_req_addr, MRA_rw, MRA_req_valid,
      output MRA_ready,
      output mem_req_valid, mem_req_addr,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
      output FIFO_wr_en, FIFO_wr_data,
      input  FIFO_full,
      output busy, err
   );

   modport master (
      output MRA_req_addr, MRA_rw, MRA_req_valid,
      input  MRA_ready,
      input  mem_req_valid, mem_req_addr,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data,
      input  FIFO_wr_en, FIFO_wr_data,
      output FIFO_full,
      input  busy, err
   );

endinterface

// File: rtl/tc_sync_fifo.sv
// rtl/tc_sync_fifo.sv - registered (non fall-through) synchronous FIFO
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, din   : write one entry (ignored when full)
//   pop         : drop the head entry (ignored when empty)
//   dout        : head entry, valid while !empty
//   full, empty : occupancy flags
// A pushed entry becomes visible the cycle after the push.
module tc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full  = (cnt_q == (PW+1)'(DEPTH));
   assign empty = (cnt_q == '0);
   assign dout  = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
   end

   // Storage is reset too so that dout reads zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/mra_resp_unit.sv
// rtl/mra_resp_unit.sv - credit-limited MRA line-read responder
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mra_resp_unit_if.slave (request, memory and WI-queue channels)
// Accepted reads are queued in reqq and issued in order to memory; returned
// lines are buffered in rspq and written one per entry into the WI queue.
// credit_cnt bounds outstanding lines to DEPTH so rspq can never overflow.
module mra_resp_unit
   import tc_mra_pkg::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 512,
   parameter int DEPTH      = 4
) (
   input logic             clk,
   input logic             rst_n,
   mra_resp_unit_if.slave  bus
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0]         credit_q, credit_d;
   logic                  err_q, err_d;

   logic                  mra_ready;
   logic                  accept;
   logic                  wr_drop;
   logic                  misalign;
   logic                  req_pop;
   logic                  req_full, req_empty;
   logic [ADDR_WIDTH-1:0] req_din, req_dout;
   logic                  rsp_push, rsp_overrun;
   logic                  rsp_full, rsp_empty;
   logic [DATA_WIDTH-1:0] rsp_dout;
   logic                  drain;

   // Misaligned requests are still served, as the enclosing line.
   assign req_din = {bus.MRA_req_addr[ADDR_WIDTH-1:LINE_OFS_BITS], {LINE_OFS_BITS{1'b0}}};

   always_comb begin
      // Ready depends on credits only; the controller qualifies valid with it.
      mra_ready   = (credit_q < CW'(DEPTH));
      // req_full cannot be set while credits remain; the term is a safety net.
      accept      = bus.MRA_req_valid & mra_ready & (bus.MRA_rw == MRA_RW_READ) & ~req_full;
      wr_drop     = bus.MRA_req_valid & mra_ready & (bus.MRA_rw == MRA_RW_WRITE);
      misalign    = accept & (bus.MRA_req_addr[LINE_OFS_BITS-1:0] != '0);
      req_pop     = ~req_empty & bus.mem_req_ready;
      rsp_push    = bus.mem_rsp_valid & ~rsp_full;
      rsp_overrun = bus.mem_rsp_valid & rsp_full;
      drain       = ~rsp_empty & ~bus.FIFO_full;
      credit_d    = credit_q + CW'(accept) - CW'(drain);
      err_d       = err_q | wr_drop | misalign | rsp_overrun;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_q <= '0;
         err_q    <= 1'b0;
      end else begin
         credit_q <= credit_d;
         err_q    <= err_d;
      end
   end

   tc_sync_fifo #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (DEPTH)
   ) u_reqq (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (accept),
      .pop   (req_pop),
      .din   (req_din),
      .dout  (req_dout),
      .full  (req_full),
      .empty (req_empty)
   );

   tc_sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_rspq (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rsp_push),
      .pop   (drain),
      .din   (bus.mem_rsp_data),
      .dout  (rsp_dout),
      .full  (rsp_full),
      .empty (rsp_empty)
   );

   assign bus.MRA_ready     = mra_ready;
   assign bus.mem_req_valid = ~req_empty;
   assign bus.mem_req_addr  = req_dout;
   assign bus.FIFO_wr_en    = drain;
   assign bus.FIFO_wr_data  = rsp_dout;
   assign bus.busy          = (credit_q != '0);
   assign bus.err           = err_q;

endmodule

// File: tb/tb_mra_resp_unit.sv
// tb/tb_mra_resp_unit.sv - directed self-checking bench for mra_resp_unit
module tb_mra_resp_unit;
   import tc_mra_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mra_resp_unit_if #(.ADDR_WIDTH(64), .DATA_WIDTH(512)) bus ();

   mra_resp_unit #(
      .ADDR_WIDTH (64),
      .DATA_WIDTH (512),
      .DEPTH      (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] mkdata(input logic [63:0] a);
      return {8{a}} ^ {64{8'hA5}};
   endfunction

   // Memory model: fixed latency, response data derived from the address.
   logic         m_v = 1'b0;
   logic [511:0] m_d = '0;
   logic         d1_v = 1'b0, d2_v = 1'b0;
   logic [63:0]  d1_a = '0, d2_a = '0;
   logic         hs;
   logic [63:0]  ha;
   assign bus.mem_rsp_valid = m_v;
   assign bus.mem_rsp_data  = m_d;

   always @(posedge clk) begin
      hs = bus.mem_req_valid & bus.mem_req_ready;
      ha = bus.mem_req_addr;
      #1;
      if (!rst_n) begin
         d1_v = 1'b0;
         d2_v = 1'b0;
         m_v  = 1'b0;
      end else begin
         m_v  = d2_v;
         m_d  = mkdata(d2_a);
         d2_v = d1_v;
         d2_a = d1_a;
         d1_v = hs;
         d1_a = ha;
      end
   end

   // Monitors of FIFO writes and memory issues, sampled mid-cycle.
   logic [511:0] got_q[$];
   logic [63:0]  iss_q[$];
   always @(negedge clk) begin
      if (rst_n && bus.FIFO_wr_en) got_q.push_back(bus.FIFO_wr_data);
      if (rst_n && bus.mem_req_valid && bus.mem_req_ready) iss_q.push_back(bus.mem_req_addr);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(tag, bus.busy, 1'b0);
   endtask

   task automatic reset_vals(input string tag);
      check({tag, "_ready"},   bus.MRA_ready, 1'b1);
      check({tag, "_mvalid"},  bus.mem_req_valid, 1'b0);
      check({tag, "_maddr"},   bus.mem_req_addr, 64'h0);
      check({tag, "_wr_en"},   bus.FIFO_wr_en, 1'b0);
      check({tag, "_wr_data"}, bus.FIFO_wr_data, 512'h0);
      check({tag, "_busy"},    bus.busy, 1'b0);
      check({tag, "_err"},     bus.err, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int base, ibase, idx, n;
      logic r, seen4, stable;

      bus.MRA_req_addr  = '0;
      bus.MRA_rw        = MRA_RW_READ;
      bus.MRA_req_valid = 1'b0;
      bus.mem_req_ready = 1'b1;
      bus.FIFO_full     = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_vals("rst");
      tick();
      rst_n = 1'b1;

      // Single read at 0x1000
      tick();
      bus.MRA_req_addr  = 64'h1000;
      bus.MRA_req_valid = 1'b1;
      @(negedge clk);
      check("t1_ready", bus.MRA_ready, 1'b1);
      tick();
      bus.MRA_req_valid = 1'b0;
      @(negedge clk);
      check("t1_mvalid", bus.mem_req_valid, 1'b1);
      check("t1_maddr", bus.mem_req_addr, 64'h1000);
      check("t1_busy", bus.busy, 1'b1);
      n = 0;
      while (!bus.mem_rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t1_rsp_seen", bus.mem_rsp_valid, 1'b1);
      check("t1_wr_en_early", bus.FIFO_wr_en, 1'b0);
      @(negedge clk);
      check("t1_wr_en", bus.FIFO_wr_en, 1'b1);
      check("t1_wr_data", bus.FIFO_wr_data, mkdata(64'h1000));
      @(negedge clk);
      check("t1_busy_done", bus.busy, 1'b0);

      // Six back-to-back requests with the WI queue full
      base = got_q.size();
      bus.FIFO_full = 1'b1;
      tick();
      idx = 0;
      seen4 = 1'b0;
      bus.MRA_req_addr  = 64'h0;
      bus.MRA_req_valid = 1'b1;
      for (int c = 0; c < 300 && idx < 6; c++) begin
         @(negedge clk);
         r = bus.MRA_ready;
         tick();
         if (r) begin
            idx++;
            bus.MRA_req_addr = 64'(idx) * 64'h40;
            if (idx == 6) bus.MRA_req_valid = 1'b0;
         end
         if (idx == 4 && !seen4) begin
            seen4 = 1'b1;
            check("t2_ready_low", bus.MRA_ready, 1'b0);
            repeat (8) @(negedge clk);
            check("t2_ready_held_low", bus.MRA_ready, 1'b0);
            check("t2_no_write_full", bus.FIFO_wr_en, 1'b0);
            tick();
            bus.FIFO_full = 1'b0;
         end
      end
      check("t2_accepts", idx, 6);
      wait_idle("t2_idle");
      check("t2_count", got_q.size() - base, 6);
      for (int i = 0; i < 6; i++) begin
         if (base + i < got_q.size()) check($sformatf("t2_line%0d", i), got_q[base+i], mkdata(64'(i) * 64'h40));
      end

      // Memory not ready for several cycles
      base  = got_q.size();
      ibase = iss_q.size();
      bus.mem_req_ready = 1'b0;
      tick();
      bus.MRA_req_addr  = 64'h200;
      bus.MRA_req_valid = 1'b1;
      tick();
      bus.MRA_req_addr  = 64'h240;
      tick();
      bus.MRA_req_valid = 1'b0;
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!(bus.mem_req_valid === 1'b1 && bus.mem_req_addr === 64'h200)) stable = 1'b0;
      end
      check("t3_stable", stable, 1'b1);
      tick();
      bus.mem_req_ready = 1'b1;
      wait_idle("t3_idle");
      check("t3_issues", iss_q.size() - ibase, 2);
      if (iss_q.size() - ibase >= 2) begin
         check("t3_iss0", iss_q[ibase], 64'h200);
         check("t3_iss1", iss_q[ibase+1], 64'h240);
      end
      check("t3_lines", got_q.size() - base, 2);

      // Same-cycle accept and drain at DEPTH-1 credits
      base = got_q.size();
      bus.FIFO_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         bus.MRA_req_addr  = 64'h300 + 64'(i) * 64'h40;
         bus.MRA_req_valid = 1'b1;
      end
      tick();
      bus.MRA_req_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("t4_credit_pre", dut.credit_q, 3'd3);
      tick();
      bus.FIFO_full     = 1'b0;
      bus.MRA_req_addr  = 64'h3C0;
      bus.MRA_req_valid = 1'b1;
      tick();
      bus.FIFO_full     = 1'b1;
      bus.MRA_req_valid = 1'b0;
      @(negedge clk);
      check("t4_credit", dut.credit_q, 3'd3);
      check("t4_ready", bus.MRA_ready, 1'b1);
      tick();
      bus.FIFO_full = 1'b0;
      wait_idle("t4_idle");
      check("t4_lines", got_q.size() - base, 4);
      for (int i = 0; i < 4; i++) begin
         if (base + i < got_q.size()) check($sformatf("t4_line%0d", i), got_q[base+i], mkdata(64'h300 + 64'(i) * 64'h40));
      end

      // Write request dropped, then misaligned read
      ibase = iss_q.size();
      tick();
      bus.MRA_rw        = MRA_RW_WRITE;
      bus.MRA_req_addr  = 64'h80;
      bus.MRA_req_valid = 1'b1;
      @(negedge clk);
      check("t5_err_pre", bus.err, 1'b0);
      tick();
      bus.MRA_rw       = MRA_RW_READ;
      bus.MRA_req_addr = 64'h44;
      @(negedge clk);
      check("t5_err_write", bus.err, 1'b1);
      check("t5_write_no_credit", bus.busy, 1'b0);
      tick();
      bus.MRA_req_valid = 1'b0;
      @(negedge clk);
      check("t5_mvalid", bus.mem_req_valid, 1'b1);
      check("t5_maddr", bus.mem_req_addr, 64'h40);
      wait_idle("t5_idle");
      check("t5_err_held", bus.err, 1'b1);
      check("t5_issues", iss_q.size() - ibase, 1);

      // Reset with three outstanding requests
      bus.mem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         bus.MRA_req_addr  = 64'h500 + 64'(i) * 64'h40;
         bus.MRA_req_valid = 1'b1;
      end
      tick();
      bus.MRA_req_valid = 1'b0;
      @(negedge clk);
      check("t6_busy_pre", bus.busy, 1'b1);
      tick();
      rst_n = 1'b0;
      #1;
      reset_vals("t6_async");
      tick();
      tick();
      rst_n = 1'b1;
      bus.mem_req_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset_vals("t6_after");
      check("t6_credit", dut.credit_q, 3'd0);

      // Misaligned read alone raises err and is issued aligned
      ibase = iss_q.size();
      tick();
      bus.MRA_req_addr  = 64'h7C4;
      bus.MRA_req_valid = 1'b1;
      tick();
      bus.MRA_req_valid = 1'b0;
      @(negedge clk);
      check("t7_err", bus.err, 1'b1);
      check("t7_maddr", bus.mem_req_addr, 64'h7C0);
      wait_idle("t7_idle");
      check("t7_issues", iss_q.size() - ibase, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
